// File: rtl/shader_loader_pkg.sv
// Shared definitions for the shader loader: host command codes and the
// loader FSM state enumeration.
package shader_loader_pkg;

  // Host command bytes (first byte of every packet)
  localparam logic [7:0] CMD_WRITE_INST = 8'h01;
  localparam logic [7:0] CMD_WRITE_DATA = 8'h02;
  localparam logic [7:0] CMD_RUN        = 8'h03;
  localparam logic [7:0] CMD_HALT       = 8'h04;

  // Loader FSM states, in packet order
  typedef enum logic [2:0] {
    IDLE,
    ADDR0,
    ADDR1,
    CNT0,
    CNT1,
    DATA,
    STROBE
  } state_t;

endpackage

// File: rtl/shader_loader.sv
// Shader loader: parses a byte stream of host packets and turns it into
// 32-bit word writes on the core's instruction/data load port, plus run
// control for the core. One FSM with address, count and word registers.
module shader_loader
  import shader_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic [ADDRESS_WIDTH-1:0] ext_write_address,
  output logic [31:0]              ext_write_data,
  output logic                     ext_enable_write_inst,
  output logic                     ext_enable_write_data,
  output logic                     run,
  output logic                     busy,
  output logic                     error
);

  state_t                   state;
  logic [7:0]               addr_lo;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [15:0]              count;
  logic [15:0]              count_full;
  logic [1:0]               byte_index;
  logic [23:0]              shift;
  logic                     is_inst;
  logic                     accept;

  assign accept     = in_valid && in_ready;
  assign count_full = {in_data, count[7:0]};
  assign busy       = (state != IDLE);

  // Packet parser: consumes accepted bytes, assembles little-endian words
  // and issues a one-cycle write strobe with registered address/data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      in_ready              <= 1'b0;
      run                   <= 1'b0;
      error                 <= 1'b0;
      ext_enable_write_inst <= 1'b0;
      ext_enable_write_data <= 1'b0;
      ext_write_address     <= '0;
      ext_write_data        <= '0;
      addr_lo               <= '0;
      addr                  <= '0;
      count                 <= '0;
      byte_index            <= '0;
      shift                 <= '0;
      is_inst               <= 1'b0;
    end else begin
      ext_enable_write_inst <= 1'b0;
      ext_enable_write_data <= 1'b0;
      in_ready              <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            case (in_data)
              CMD_WRITE_INST: begin
                is_inst <= 1'b1;
                run     <= 1'b0;
                state   <= ADDR0;
              end
              CMD_WRITE_DATA: begin
                is_inst <= 1'b0;
                run     <= 1'b0;
                state   <= ADDR0;
              end
              CMD_RUN:  run   <= 1'b1;
              CMD_HALT: run   <= 1'b0;
              default:  error <= 1'b1;
            endcase
          end
        end
        ADDR0: begin
          if (accept) begin
            addr_lo <= in_data;
            state   <= ADDR1;
          end
        end
        ADDR1: begin
          if (accept) begin
            addr  <= ADDRESS_WIDTH'({in_data, addr_lo});
            state <= CNT0;
          end
        end
        CNT0: begin
          if (accept) begin
            count[7:0] <= in_data;
            state      <= CNT1;
          end
        end
        CNT1: begin
          if (accept) begin
            count      <= count_full;
            byte_index <= 2'd0;
            state      <= (count_full == 16'd0) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            shift      <= {in_data, shift[23:8]};
            byte_index <= byte_index + 2'd1;
            if (byte_index == 2'd3) begin
              ext_write_data        <= {in_data, shift};
              ext_write_address     <= addr;
              ext_enable_write_inst <= is_inst;
              ext_enable_write_data <= !is_inst;
              in_ready              <= 1'b0;
              state                 <= STROBE;
            end
          end
        end
        STROBE: begin
          addr  <= addr + ADDRESS_WIDTH'(4);
          count <= count - 16'd1;
          state <= (count != 16'd1) ? DATA : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shader_loader.sv
// Self-checking bench for shader_loader: a table of fixed packets, a few
// hand-written corner sequences, and random packets against a model.
module tb_shader_loader;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] ext_write_address;
  logic [31:0] ext_write_data;
  logic        ext_enable_write_inst;
  logic        ext_enable_write_data;
  logic        run;
  logic        busy;
  logic        error;

  int testsRun = 0;
  int failures = 0;

  typedef struct packed {
    logic        inst;
    logic [15:0] addr;
    logic [31:0] data;
  } write_t;

  typedef struct {
    logic [103:0] raw;
    int           len;
    int           pulses;
    logic         inst;
    logic [15:0]  addr;
    logic [31:0]  data;
    logic [15:0]  heldAddr;
    logic [31:0]  heldData;
    logic         expRun;
    logic         expError;
  } vec_t;

  write_t observedQ[$];
  write_t expectedQ[$];
  vec_t   vecs[8];
  logic [7:0] pkt[$];

  logic [15:0] modelAddr;
  logic [31:0] modelData;
  logic        modelRun;
  logic        modelError;

  shader_loader #(.ADDRESS_WIDTH(16)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .in_valid              (in_valid),
    .in_data               (in_data),
    .in_ready              (in_ready),
    .ext_write_address     (ext_write_address),
    .ext_write_data        (ext_write_data),
    .ext_enable_write_inst (ext_enable_write_inst),
    .ext_enable_write_data (ext_enable_write_data),
    .run                   (run),
    .busy                  (busy),
    .error                 (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Strobe monitor: records every write and checks handshake rules per cycle
  always @(negedge clock) begin
    if (reset_n) begin
      if (ext_enable_write_inst || ext_enable_write_data) begin
        observedQ.push_back({ext_enable_write_inst, ext_write_address, ext_write_data});
        checkOutput("one enable only", {31'd0, ext_enable_write_inst ^ ext_enable_write_data}, 32'd1);
        checkOutput("in_ready low in strobe", {31'd0, in_ready}, 32'd0);
      end else if (busy) begin
        checkOutput("in_ready high while busy", {31'd0, in_ready}, 32'd1);
      end
    end
  end

  // Drive one byte with in_valid held; returns at the negedge after acceptance
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clock);
      waitCycles++;
    end
    checkOutput("in_ready before accept", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
  endtask

  task automatic sendPacket();
    foreach (pkt[i]) applyStimulus(pkt[i]);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic checkWrites(input string name);
    checkOutput({name, " write count"}, 32'(observedQ.size()), 32'(expectedQ.size()));
    while (observedQ.size() > 0 && expectedQ.size() > 0) begin
      write_t o = observedQ.pop_front();
      write_t e = expectedQ.pop_front();
      checkOutput({name, " write inst"}, {31'd0, o.inst}, {31'd0, e.inst});
      checkOutput({name, " write addr"}, {16'd0, o.addr}, {16'd0, e.addr});
      checkOutput({name, " write data"}, o.data, e.data);
    end
    observedQ.delete();
    expectedQ.delete();
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " run"}, {31'd0, run}, {31'd0, modelRun});
    checkOutput({name, " error"}, {31'd0, error}, {31'd0, modelError});
    checkOutput({name, " busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, " held addr"}, {16'd0, ext_write_address}, {16'd0, modelAddr});
    checkOutput({name, " held data"}, ext_write_data, modelData);
  endtask

  task automatic setVec(input int idx, input logic [103:0] raw, input int len,
                        input int pulses, input logic inst, input logic [15:0] addr,
                        input logic [31:0] data, input logic [15:0] heldAddr,
                        input logic [31:0] heldData, input logic expRun,
                        input logic expError);
    vecs[idx].raw      = raw;
    vecs[idx].len      = len;
    vecs[idx].pulses   = pulses;
    vecs[idx].inst     = inst;
    vecs[idx].addr     = addr;
    vecs[idx].data     = data;
    vecs[idx].heldAddr = heldAddr;
    vecs[idx].heldData = heldData;
    vecs[idx].expRun   = expRun;
    vecs[idx].expError = expError;
  endtask

  // Reference model: expected writes from a packet using plain arithmetic
  task automatic modelPacket();
    logic [7:0]  cmd;
    logic [15:0] base;
    int          cnt;
    cmd = pkt[0];
    if (cmd == 8'h01 || cmd == 8'h02) begin
      modelRun = 1'b0;
      base = {pkt[2], pkt[1]};
      cnt  = int'({pkt[4], pkt[3]});
      for (int w = 0; w < cnt; w++) begin
        write_t e;
        e.inst = (cmd == 8'h01);
        e.addr = 16'(int'(base) + 4 * w);
        e.data = {pkt[5+4*w+3], pkt[5+4*w+2], pkt[5+4*w+1], pkt[5+4*w]};
        expectedQ.push_back(e);
        modelAddr = e.addr;
        modelData = e.data;
      end
    end else if (cmd == 8'h03) begin
      modelRun = 1'b1;
    end else if (cmd == 8'h04) begin
      modelRun = 1'b0;
    end else begin
      modelError = 1'b1;
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    modelAddr = 16'h0; modelData = 32'h0; modelRun = 1'b0; modelError = 1'b0;

    // Fixed packet table; state (run/error/held outputs) carries across rows
    setVec(0, 104'h010000010078563412, 9, 1, 1'b1, 16'h0000, 32'h12345678, 16'h0000, 32'h12345678, 1'b0, 1'b0);
    setVec(1, 104'h03,                 1, 0, 1'b0, 16'h0000, 32'h0,        16'h0000, 32'h12345678, 1'b1, 1'b0);
    setVec(2, 104'h0110000000,         5, 0, 1'b0, 16'h0000, 32'h0,        16'h0000, 32'h12345678, 1'b0, 1'b0);
    setVec(3, 104'h03,                 1, 0, 1'b0, 16'h0000, 32'h0,        16'h0000, 32'h12345678, 1'b1, 1'b0);
    setVec(4, 104'h04,                 1, 0, 1'b0, 16'h0000, 32'h0,        16'h0000, 32'h12345678, 1'b0, 1'b0);
    setVec(5, 104'h7F,                 1, 0, 1'b0, 16'h0000, 32'h0,        16'h0000, 32'h12345678, 1'b0, 1'b1);
    setVec(6, 104'h02341201_00EFBEADDE, 9, 1, 1'b0, 16'h1234, 32'hDEADBEEF, 16'h1234, 32'hDEADBEEF, 1'b0, 1'b1);
    setVec(7, 104'h00,                 1, 0, 1'b0, 16'h0000, 32'h0,        16'h1234, 32'hDEADBEEF, 1'b0, 1'b1);

    // Reset values, and in_ready registered after release
    #3;
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset addr", {16'd0, ext_write_address}, 32'd0);
    checkOutput("reset data", ext_write_data, 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    #1 checkOutput("in_ready before first edge", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    checkOutput("in_ready after first edge", {31'd0, in_ready}, 32'd1);

    for (int v = 0; v < 8; v++) begin
      observedQ.delete();
      pkt.delete();
      for (int k = 0; k < vecs[v].len; k++) pkt.push_back(vecs[v].raw[8*(vecs[v].len-1-k) +: 8]);
      sendPacket();
      checkOutput($sformatf("vec%0d pulses", v), 32'(observedQ.size()), 32'(vecs[v].pulses));
      if (observedQ.size() > 0) begin
        checkOutput($sformatf("vec%0d inst", v), {31'd0, observedQ[0].inst}, {31'd0, vecs[v].inst});
        checkOutput($sformatf("vec%0d addr", v), {16'd0, observedQ[0].addr}, {16'd0, vecs[v].addr});
        checkOutput($sformatf("vec%0d data", v), observedQ[0].data, vecs[v].data);
      end
      checkOutput($sformatf("vec%0d run", v), {31'd0, run}, {31'd0, vecs[v].expRun});
      checkOutput($sformatf("vec%0d error", v), {31'd0, error}, {31'd0, vecs[v].expError});
      checkOutput($sformatf("vec%0d busy", v), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("vec%0d held addr", v), {16'd0, ext_write_address}, {16'd0, vecs[v].heldAddr});
      checkOutput($sformatf("vec%0d held data", v), ext_write_data, vecs[v].heldData);
    end
    observedQ.delete();
    modelAddr = 16'h1234; modelData = 32'hDEADBEEF; modelRun = 1'b0; modelError = 1'b1;

    // Address wrap across two back-to-back data words
    pkt = '{8'h02, 8'hFC, 8'hFF, 8'h02, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    expectedQ.push_back({1'b0, 16'hFFFC, 32'h44332211});
    expectedQ.push_back({1'b0, 16'h0000, 32'hDDCCBBAA});
    modelAddr = 16'h0000; modelData = 32'hDDCCBBAA;
    sendPacket();
    checkWrites("wrap");
    checkIdle("wrap");

    // Reset in the middle of a word: no strobe, everything back to reset values
    pkt = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56};
    foreach (pkt[i]) applyStimulus(pkt[i]);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset run", {31'd0, run}, 32'd0);
    checkOutput("midreset error", {31'd0, error}, 32'd0);
    checkOutput("midreset enables", {30'd0, ext_enable_write_inst, ext_enable_write_data}, 32'd0);
    checkOutput("midreset addr", {16'd0, ext_write_address}, 32'd0);
    checkOutput("midreset data", ext_write_data, 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    checkWrites("midreset");
    modelAddr = 16'h0; modelData = 32'h0; modelRun = 1'b0; modelError = 1'b0;
    pkt = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    modelPacket();
    sendPacket();
    checkWrites("after reset");
    checkIdle("after reset");

    // Random packets against the reference model
    for (int p = 0; p < 40; p++) begin
      int kind = $urandom_range(0, 9);
      pkt.delete();
      if (kind <= 5) begin
        int cnt = $urandom_range(0, 3);
        logic [15:0] a = 16'($urandom_range(0, 65535));
        pkt.push_back((kind < 3) ? 8'h01 : 8'h02);
        pkt.push_back(a[7:0]);
        pkt.push_back(a[15:8]);
        pkt.push_back(8'(cnt));
        pkt.push_back(8'h00);
        for (int k = 0; k < 4 * cnt; k++) pkt.push_back(8'($urandom_range(0, 255)));
      end else if (kind == 6) begin
        pkt.push_back(8'h03);
      end else if (kind == 7) begin
        pkt.push_back(8'h04);
      end else if (kind == 8) begin
        pkt.push_back(8'($urandom_range(5, 255)));
      end else begin
        pkt.push_back(8'h00);
      end
      modelPacket();
      sendPacket();
      checkWrites($sformatf("rand%0d", p));
      checkIdle($sformatf("rand%0d", p));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/shader_loader.md
SHADER_LOADER -- requirements
Module: shader_loader

Interface
REQ-001 Parameter: ADDRESS_WIDTH, 16, width of the generated byte address and of ext_write_address.
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  host byte present.
REQ-005 in_data  input  8  host byte.
REQ-006 in_ready  output  1  byte accepted when in_valid && in_ready at a rising edge.
REQ-007 ext_write_address  output  ADDRESS_WIDTH  byte address of the current word; connects to core load port.
REQ-008 ext_write_data  output  32  word to write.
REQ-009 ext_enable_write_inst  output  1  one-cycle strobe, instruction RAM write.
REQ-010 ext_enable_write_data  output  1  one-cycle strobe, data RAM write.
REQ-011 run  output  1  core run control; low means the core accepts load-port writes.
REQ-012 busy  output  1  high whenever state != IDLE.
REQ-013 error  output  1  sticky illegal-command flag.

Function
REQ-014 The byte stream SHALL be packets, first byte a command: 0x01 WRITE_INST, 0x02 WRITE_DATA, 0x03 RUN, 0x04 HALT.
REQ-015 WRITE_INST/WRITE_DATA SHALL be followed by addr_lo, addr_hi (byte address), cnt_lo, cnt_hi (word count), then cnt words, 4 bytes each, little-endian.
REQ-016 States SHALL be IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, STROBE; each accepted byte advances IDLE->ADDR0->ADDR1->CNT0->CNT1->DATA.
REQ-017 In DATA a 2-bit byte index SHALL count 0..3; the 4th accepted byte moves to STROBE.
REQ-018 In STROBE, held exactly one cycle, the selected enable SHALL be 1 with ext_write_address/ext_write_data stable; the other enable stays 0.
REQ-019 After STROBE the address SHALL increment by 4, modulo 2^ADDRESS_WIDTH, and the remaining count decrement; next state DATA if remaining != 0, else IDLE.
REQ-020 cnt == 0 SHALL return CNT1 to IDLE with no strobe.
REQ-021 in_ready SHALL be registered: 1 in every state except STROBE, and 0 during the STROBE cycle.
REQ-022 Accepting WRITE_INST/WRITE_DATA SHALL drive run to 0 on the next edge, before any strobe.
REQ-023 RUN SHALL set run=1; HALT SHALL set run=0; both are single-byte packets returning to IDLE.
REQ-024 An unknown command byte SHALL set error, be discarded, and leave the state IDLE; error clears only on reset.
REQ-025 ext_write_address/ext_write_data SHALL hold their last values outside STROBE.
REQ-026 in_valid while in_ready=0 SHALL NOT be consumed; the host holds the byte.

Reset
REQ-027 reset_n low SHALL asynchronously force state IDLE, run 0, both enables 0, busy 0, error 0, in_ready 0, ext_write_address 0, ext_write_data 0, count 0, byte index 0.
REQ-028 in_ready SHALL rise on the first clock edge after reset_n deasserts.
REQ-029 Reset mid-packet SHALL abandon the packet; no strobe is issued for a partial word.

Structure
REQ-030 Command codes and the state enumeration SHALL live in shared package shader_loader_pkg.
REQ-031 No sub-module is required; the block is one FSM plus address, count, and word shift registers.

Verification
REQ-032 Bytes 01 00 00 01 00 78 56 34 12 -> one ext_enable_write_inst pulse, address 0x0000, data 0x12345678; busy low afterwards.
REQ-033 Bytes 02 FC FF 02 00 + 8 payload bytes -> data strobes at 0xFFFC then 0x0000 (wrap), two pulses, no inst pulse.
REQ-034 RUN byte 03, then 01 10 00 00 00 -> run rises after 03, falls after 01; no strobe; state IDLE.
REQ-035 Byte 7F -> error=1 and stays 1; following valid WRITE_DATA packet still completes correctly.
REQ-036 in_valid held high with back-to-back words -> in_ready low exactly in each STROBE cycle; no byte lost or duplicated.
REQ-037 reset_n pulsed low after 2 payload bytes -> no strobe; all outputs at reset values; next packet decodes from its command byte.
